// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stopwatch_ctrl_if : command inputs and display/status outputs        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface stopwatch_ctrl_if;
  logic       enable;
  logic [2:0] cmd;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [3:0] cs_tens;
  logic [3:0] cs_ones;
  logic [1:0] fsm_state;
  logic       running;
  logic       ovf;

  modport master (
    output enable, cmd,
    input  min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones,
    input  fsm_state, running, ovf
  );

  modport slave (
    input  enable, cmd,
    output min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones,
    output fsm_state, running, ovf
  );
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stopwatch_ctrl : command FSM, centisecond prescaler, BCD mm:ss.cc    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module stopwatch_ctrl #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  stopwatch_ctrl_if.slave bus
);
  localparam int              DIV       = CLK_HZ / TICK_HZ;
  localparam int              PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(DIV - 1);
  localparam logic [2:0]      CMD_RESET = 3'b001;
  localparam logic [2:0]      CMD_COUNT = 3'b010;
  localparam logic [2:0]      CMD_PAUSE = 3'b011;
  localparam logic [2:0]      CMD_STOP  = 3'b100;
  // Digit index 0 = cs_ones ... 5 = min_tens
  localparam logic [5:0][3:0] DIG_MAX   = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RUN     = 2'b01,
    S_PAUSED  = 2'b10,
    S_STOPPED = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      cmd_prev_q;
  logic            armed_q;
  logic [PW-1:0]   presc_q, presc_d;
  logic [5:0][3:0] dig_q, dig_d;
  logic            ovf_q, ovf_d;
  logic            cmd_valid, cmd_evt, tick, clear, carry;

  // armed_q blocks the first edge after reset release, so a command level
  // held through reset needs a fresh change before it fires.
  always_comb begin
    cmd_valid = (bus.cmd >= CMD_RESET) && (bus.cmd <= CMD_STOP);
    cmd_evt   = armed_q && bus.enable && (bus.cmd != cmd_prev_q) && cmd_valid;
    tick      = (state_q == S_RUN) && (presc_q == PRESC_MAX);
    clear     = cmd_evt && (bus.cmd == CMD_RESET);
  end

  always_comb begin
    state_d = state_q;
    if (cmd_evt) begin
      case (state_q)
        S_IDLE: begin
          if (bus.cmd == CMD_COUNT) state_d = S_RUN;
        end
        S_RUN: begin
          if (bus.cmd == CMD_PAUSE)     state_d = S_PAUSED;
          else if (bus.cmd == CMD_STOP) state_d = S_STOPPED;
        end
        S_PAUSED: begin
          if (bus.cmd == CMD_COUNT)     state_d = S_RUN;
          else if (bus.cmd == CMD_STOP) state_d = S_STOPPED;
        end
        default: state_d = state_q;
      endcase
      if (clear) state_d = S_IDLE;
    end
  end

  always_comb begin
    presc_d = presc_q;
    dig_d   = dig_q;
    ovf_d   = ovf_q;
    carry   = tick;
    if (state_q == S_RUN) presc_d = tick ? '0 : presc_q + 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (dig_q[i] >= DIG_MAX[i]) begin
          dig_d[i] = 4'd0;
        end else begin
          dig_d[i] = dig_q[i] + 4'd1;
          carry    = 1'b0;
        end
      end
    end
    if (carry) ovf_d = 1'b1;
    // Clear overrides any same-cycle increment or wrap.
    if (clear) begin
      presc_d = '0;
      dig_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cmd_prev_q <= 3'b000;
      armed_q    <= 1'b0;
      presc_q    <= '0;
      dig_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_prev_q <= bus.cmd;
      armed_q    <= 1'b1;
      presc_q    <= presc_d;
      dig_q      <= dig_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.cs_ones   = dig_q[0];
  assign bus.cs_tens   = dig_q[1];
  assign bus.sec_ones  = dig_q[2];
  assign bus.sec_tens  = dig_q[3];
  assign bus.min_ones  = dig_q[4];
  assign bus.min_tens  = dig_q[5];
  assign bus.fsm_state = state_q;
  assign bus.running   = (state_q == S_RUN);
  assign bus.ovf       = ovf_q;
endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_stopwatch_ctrl : randomized + directed bench with a time model    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_stopwatch_ctrl;
  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV     = CLK_HZ / TICK_HZ;
  localparam int WRAP    = 360000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [27:0] obs;
  assign obs = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones,
                bus.cs_tens, bus.cs_ones, bus.fsm_state, bus.running, bus.ovf};

  // Model: elapsed time as a plain centisecond total; state 0..3 as in fsm_state
  int         m_state, m_total, m_presc;
  bit         m_ovf, m_armed;
  logic [2:0] m_prev;

  task automatic model_reset();
    m_state = 0; m_total = 0; m_presc = 0; m_ovf = 0; m_armed = 0; m_prev = 3'b000;
  endtask

  task automatic model_edge();
    int c;
    bit ev, tk;
    if (!rst_n) begin
      model_reset();
      return;
    end
    c  = int'(bus.cmd);
    ev = m_armed && bus.enable && (bus.cmd != m_prev) && (c >= 1) && (c <= 4);
    m_prev  = bus.cmd;
    m_armed = 1;
    tk = (m_state == 1) && (m_presc == DIV - 1);
    if (ev && c == 1) begin
      m_state = 0; m_total = 0; m_presc = 0; m_ovf = 0;
      return;
    end
    if (m_state == 1) begin
      m_presc = (m_presc + 1) % DIV;
      if (tk) begin
        m_total = m_total + 1;
        if (m_total == WRAP) begin
          m_total = 0;
          m_ovf   = 1;
        end
      end
    end
    if (ev) begin
      if (m_state == 0 && c == 2) m_state = 1;
      else if ((m_state == 1 || m_state == 2) && c == 4) m_state = 3;
      else if (m_state == 1 && c == 3) m_state = 2;
      else if (m_state == 2 && c == 2) m_state = 1;
    end
  endtask

  function automatic logic [27:0] exp_vec();
    int mm, ss, cc;
    mm = m_total / 6000;
    ss = (m_total / 100) % 60;
    cc = m_total % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10),
            2'(m_state), (m_state == 1), m_ovf};
  endfunction

  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      model_edge();
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bus.enable = 1'b1; bus.cmd = 3'b000;
    model_reset();
    cycle(2);
    rst_n = 1'b1;
    cycle(1);
  endtask

  task automatic do_start();
    bus.cmd = 3'b010;
    cycle(1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.enable = 1'b0; bus.cmd = 3'b000;
    model_reset();
    cycle(2);
    checks++;
    if (obs !== 28'h0) begin
      errors++; $display("FAIL reset_values: got %h expected %h", obs, 28'h0);
    end
    rst_n = 1'b1;
    cycle(2);
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL reset_release: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_start();
    do_reset();
    do_start();
    checks++;
    if (bus.fsm_state !== 2'b01 || bus.running !== 1'b1) begin
      errors++; $display("FAIL start_state: got %b/%b expected 01/1", bus.fsm_state, bus.running);
    end
    cycle(9);
    checks++;
    if (bus.cs_ones !== 4'd0) begin
      errors++; $display("FAIL start_no_early_tick: got %0d expected 0", bus.cs_ones);
    end
    cycle(1);
    checks++;
    if (bus.cs_ones !== 4'd1 || obs !== exp_vec()) begin
      errors++; $display("FAIL start_first_tick: got %h expected %h", obs, exp_vec());
    end
    cycle(990);
    checks++;
    if (obs !== {24'h000100, 2'b01, 1'b1, 1'b0}) begin
      errors++; $display("FAIL start_one_second: got %h expected %h", obs, {24'h000100, 4'b0110});
    end
  endtask

  task automatic test_pause_resume();
    int n;
    do_reset();
    do_start();
    n = 0;
    while (!(m_total == 5 && m_presc == 3) && n < 200) begin
      cycle(1); n++;
    end
    checks++;
    if (n >= 200) begin
      errors++; $display("FAIL pause_reach_timeout: got %0d expected <200", n);
    end
    bus.cmd = 3'b011;
    cycle(1);
    cycle(500);
    checks++;
    if (obs !== {24'h000005, 2'b10, 1'b0, 1'b0}) begin
      errors++; $display("FAIL pause_hold: got %h expected %h", obs, {24'h000005, 4'b1000});
    end
    bus.cmd = 3'b010;
    cycle(1);
    n = 0;
    while (bus.cs_ones === 4'd5 && n < 20) begin
      cycle(1); n++;
    end
    checks++;
    if (n != 6 || obs !== {24'h000006, 2'b01, 1'b1, 1'b0}) begin
      errors++; $display("FAIL resume_phase: got %0d cycles %h expected 6 cycles %h",
                         n, obs, {24'h000006, 4'b0110});
    end
  endtask

  task automatic test_stop_lock();
    int n;
    logic [27:0] want;
    do_reset();
    do_start();
    n = 0;
    while (!(m_total == 237 && m_presc < 5) && n < 3000) begin
      cycle(1); n++;
    end
    bus.cmd = 3'b100;
    cycle(1);
    want = {24'h000237, 2'b11, 1'b0, 1'b0};
    checks++;
    if (obs !== want) begin
      errors++; $display("FAIL stop_enter: got %h expected %h", obs, want);
    end
    bus.cmd = 3'b010;
    cycle(3);
    bus.cmd = 3'b011;
    cycle(3);
    checks++;
    if (obs !== want) begin
      errors++; $display("FAIL stop_locked: got %h expected %h", obs, want);
    end
    bus.cmd = 3'b001;
    cycle(1);
    checks++;
    if (obs !== 28'h0) begin
      errors++; $display("FAIL stop_reset: got %h expected %h", obs, 28'h0);
    end
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    do_start();
    cycle(3);
    bus.cmd = 3'b011;
    cycle(1);
    force dut.dig_q = 24'h595999;
    m_total = WRAP - 1;
    cycle(1);
    release dut.dig_q;
    cycle(1);
    checks++;
    if (obs !== {24'h595999, 2'b10, 1'b0, 1'b0}) begin
      errors++; $display("FAIL wrap_preload: got %h expected %h", obs, {24'h595999, 4'b1000});
    end
    bus.cmd = 3'b010;
    cycle(1);
    n = 0;
    while (bus.cs_ones === 4'd9 && n < 20) begin
      cycle(1); n++;
    end
    checks++;
    if (obs !== {24'h000000, 2'b01, 1'b1, 1'b1} || obs !== exp_vec()) begin
      errors++; $display("FAIL wrap_tick: got %h expected %h", obs, {24'h000000, 4'b0111});
    end
    cycle(15);
    checks++;
    if (bus.ovf !== 1'b1 || obs !== exp_vec()) begin
      errors++; $display("FAIL wrap_sticky: got %h expected %h", obs, exp_vec());
    end
    bus.cmd = 3'b001;
    cycle(1);
    checks++;
    if (obs !== 28'h0) begin
      errors++; $display("FAIL wrap_clear: got %h expected %h", obs, 28'h0);
    end
  endtask

  task automatic test_gating();
    int n;
    do_reset();
    bus.enable = 1'b0;
    bus.cmd = 3'b010;
    cycle(3);
    checks++;
    if (obs !== 28'h0) begin
      errors++; $display("FAIL gate_disabled: got %h expected %h", obs, 28'h0);
    end
    bus.enable = 1'b1;
    cycle(3);
    checks++;
    if (obs !== 28'h0) begin
      errors++; $display("FAIL gate_held_level: got %h expected %h", obs, 28'h0);
    end
    bus.cmd = 3'b000;
    cycle(1);
    do_start();
    n = 0;
    while (!(m_presc == DIV - 1 && m_total >= 2) && n < 100) begin
      cycle(1); n++;
    end
    bus.cmd = 3'b001;
    cycle(1);
    checks++;
    if (obs !== 28'h0 || obs !== exp_vec()) begin
      errors++; $display("FAIL reset_on_tick: got %h expected %h", obs, 28'h0);
    end
  endtask

  task automatic test_async_reset();
    int n;
    do_reset();
    do_start();
    n = 0;
    while (m_total != 341 && n < 4000) begin
      cycle(1); n++;
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs !== 28'h0) begin
      errors++; $display("FAIL async_reset_immediate: got %h expected %h", obs, 28'h0);
    end
    cycle(2);
    rst_n = 1'b1;
    cycle(5);
    checks++;
    if (obs !== 28'h0 || obs !== exp_vec()) begin
      errors++; $display("FAIL async_release_idle: got %h expected %h", obs, 28'h0);
    end
    bus.cmd = 3'b000;
    cycle(1);
    do_start();
    checks++;
    if (obs !== exp_vec() || bus.fsm_state !== 2'b01) begin
      errors++; $display("FAIL async_fresh_start: got %h expected %h", obs, exp_vec());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) bus.cmd = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) bus.enable = ~bus.enable;
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end
      cycle(1);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random_step %0d: got %h expected %h", i, obs, exp_vec());
      end
    end
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.cmd    = 3'b000;
    model_reset();
    @(negedge clk);
    test_reset();
    test_start();
    test_pause_resume();
    test_stop_lock();
    test_wrap();
    test_gating();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
